// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-producer bit per register, issue set beats write-back clear.
// REGFILE_BYPASS_EN exposes the post-update vector for write-first reads.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
`ifdef REGFILE_BYPASS_EN
  output logic [NREGS-1:0]  busy_next,
`endif
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] nxt;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    nxt = busy_vec;
    for (int p = 0; p < NWR; p++) begin
      if (clr_en[p] && clr_addr[p*AW +: AW] != '0)
        nxt[clr_addr[p*AW +: AW]] = 1'b0;
    end
    // Applied after the clears so a new producer issued this cycle stays pending.
    if (iss_en && iss_rd != '0)
      nxt[iss_rd] = 1'b1;
    nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= nxt;
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_next = nxt;
`endif

endmodule

// File: rtl/reg_file_mp.sv
// NRD-read / NWR-write register file with x0 hard-wired to zero and a busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_d;
`ifdef REGFILE_BYPASS_EN
  logic [NREGS-1:0]    busy_next;
`endif

  rf_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
`ifdef REGFILE_BYPASS_EN
    .busy_next(busy_next),
`endif
    .busy_vec (busy_vec)
  );

  // NOTE: the array is reset because outputs must be X-free right after reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      // Ascending port order: the last assignment, i.e. the highest port, wins a collision.
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] != '0)
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int q = 0; q < NRD; q++) begin
      rd_data_d[q*XLEN +: XLEN] = regs[rd_addr[q*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      rd_busy_d[q] = busy_next[rd_addr[q*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == rd_addr[q*AW +: AW])
          rd_data_d[q*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
      end
`else
      rd_busy_d[q] = busy_vec[rd_addr[q*AW +: AW]];
`endif
      if (rd_addr[q*AW +: AW] == '0) begin
        rd_data_d[q*XLEN +: XLEN] = '0;
        rd_busy_d[q]              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rd_data <= rd_data_d;
      rd_busy <= rd_busy_d;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic [NREGS-1:0]    busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_en  = 1'b0;
    iss_rd  = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    wr_en[p]                 = 1'b1;
    wr_addr[p*AW +: AW]      = a5;
    wr_data[p*XLEN +: XLEN]  = d;
  endtask

  task automatic set_rd(input int q, input int a);
    logic [AW-1:0] a5;
    a5 = AW'(a);
    rd_addr[q*AW +: AW] = a5;
  endtask

  function automatic logic [XLEN-1:0] rdq(input int q);
    return rd_data[q*XLEN +: XLEN];
  endfunction

  task automatic test_reset();
    logic [XLEN-1:0] got;
    reset = 1'b1;
    idle_writes();
    rd_addr = '0;
    #12;
    n_tests++;
    if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_init: rd_data=%h rd_busy=%b busy_vec=%h, want all 0", rd_data, rd_busy, busy_vec);
    end
    reset = 1'b0;
    tick();

    set_wr(0, 5, 64'hDEAD);
    tick();
    idle_writes();
    set_rd(0, 5);
    iss_en = 1'b1;
    iss_rd = 5'd5;
    tick();
    idle_writes();
    got = rdq(0);
    n_tests++;
    if (got !== 64'hDEAD || busy_vec[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: x5=%h busy5=%b, want DEAD 1", got, busy_vec[5]);
    end

    reset = 1'b1;
    #3;
    n_tests++;
    if (rd_data !== '0 || busy_vec !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rd_data=%h busy_vec=%h rd_busy=%b, want 0", rd_data, busy_vec, rd_busy);
    end
    #1;
    reset = 1'b0;
    tick();
    got = rdq(0);
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_x5_after: got %h want 0", got);
    end
  endtask

  task automatic test_x0();
    set_wr(0, 0, 64'hFFFF);
    iss_en = 1'b1;
    iss_rd = '0;
    set_rd(0, 0);
    set_rd(1, 0);
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec !== '0 || rdq(0) !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL x0_same: busy_vec=%h rd0=%h rd_busy=%b, want 0", busy_vec, rdq(0), rd_busy);
    end
    tick();
    n_tests++;
    if (rdq(0) !== '0 || rdq(1) !== '0 || busy_vec[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_read: rd0=%h rd1=%h busy0=%b, want 0", rdq(0), rdq(1), busy_vec[0]);
    end
  endtask

  task automatic test_collision();
    iss_en = 1'b1;
    iss_rd = 5'd7;
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_issue: busy7=%b want 1", busy_vec[7]);
    end
    set_wr(0, 7, 64'h11);
    set_wr(1, 7, 64'h22);
    set_rd(0, 7);
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec[7] !== 1'b0 || busy_vec !== '0) begin
      n_fail++;
      $display("FAIL coll_busy: busy_vec=%h want 0", busy_vec);
    end
    n_tests++;
    if (rdq(0) !== (BYPASS ? 64'h22 : 64'h0)) begin
      n_fail++;
      $display("FAIL coll_same_cycle: got %h want %h", rdq(0), BYPASS ? 64'h22 : 64'h0);
    end
    tick();
    n_tests++;
    if (rdq(0) !== 64'h22) begin
      n_fail++;
      $display("FAIL coll_data: got %h want 22", rdq(0));
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [XLEN-1:0] exp;
    set_wr(0, 3, 64'hAA);
    tick();
    idle_writes();
    set_wr(1, 3, 64'hBB);
    set_rd(0, 3);
    set_rd(1, 3);
    tick();
    idle_writes();
    exp = BYPASS ? 64'hBB : 64'hAA;
    n_tests++;
    if (rdq(0) !== exp || rdq(1) !== exp) begin
      n_fail++;
      $display("FAIL rw_same: rd0=%h rd1=%h want %h", rdq(0), rdq(1), exp);
    end
    tick();
    n_tests++;
    if (rdq(0) !== 64'hBB || rdq(1) !== 64'hBB) begin
      n_fail++;
      $display("FAIL rw_next: rd0=%h rd1=%h want BB", rdq(0), rdq(1));
    end
  endtask

  task automatic test_scoreboard();
    set_rd(1, 9);
    iss_en = 1'b1;
    iss_rd = 5'd9;
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec !== 32'h0000_0200 || rd_busy[1] !== BYPASS) begin
      n_fail++;
      $display("FAIL sb_issue: busy_vec=%h rd_busy1=%b want 00000200 %b", busy_vec, rd_busy[1], BYPASS);
    end
    iss_en = 1'b1;
    iss_rd = 5'd9;
    set_wr(0, 9, 64'h99);
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec[9] !== 1'b1 || rd_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: busy9=%b rd_busy1=%b want 1 1", busy_vec[9], rd_busy[1]);
    end
    set_wr(1, 9, 64'h9A);
    tick();
    idle_writes();
    n_tests++;
    if (busy_vec[9] !== 1'b0 || rd_busy[1] !== !BYPASS) begin
      n_fail++;
      $display("FAIL sb_clear: busy9=%b rd_busy1=%b want 0 %b", busy_vec[9], rd_busy[1], !BYPASS);
    end
  endtask

  task automatic test_all_ports();
    logic [XLEN-1:0] e0, e1;
    for (int i = 1; i < NREGS; i += 2) begin
      set_wr(0, i, 64'(i) * 64'h0101);
      if (i + 1 < NREGS) set_wr(1, i + 1, 64'(i + 1) * 64'h0101);
      tick();
      idle_writes();
    end
    for (int i = 1; i < 16; i++) begin
      set_rd(0, i);
      set_rd(1, NREGS - i);
      tick();
      e0 = 64'(i) * 64'h0101;
      e1 = 64'(NREGS - i) * 64'h0101;
      n_tests++;
      if (rdq(0) !== e0 || rdq(1) !== e1 || rd_busy !== '0) begin
        n_fail++;
        $display("FAIL all_ports[%0d]: rd0=%h rd1=%h busy=%b want %h %h 00", i, rdq(0), rdq(1), rd_busy, e0, e1);
      end
    end
  endtask

  initial begin
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; iss_en = 1'b0; iss_rd = '0;
    test_reset();
    test_x0();
    test_collision();
    test_rw_same_cycle();
    test_scoreboard();
    test_all_ports();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
